// File: rtl/mpw_wb_gpio_regbank_if.sv
// -----------------------------------------------------------------------------
// mpw_wb_gpio_regbank_if
// Wishbone slave-side signal bundle for mpw_wb_gpio_regbank.
//
// Signals (names follow the Caravel wrapper's Wishbone port names):
//   wbs_cyc_i  bus cycle          wbs_stb_i  strobe
//   wbs_we_i   write enable       wbs_sel_i  byte enables [3:0]
//   wbs_adr_i  byte address [31:0]
//   wbs_dat_i  write data [31:0]
//   wbs_ack_o  acknowledge        wbs_dat_o  read data [31:0]
//
// Modports: master drives the request, slave drives ack/read data.
//
// Handshake: a request is cyc & stb held until ack. The slave raises ack for
// exactly one cycle; read data is valid only while ack is high, and a write is
// committed at the end of the ack cycle only if cyc & stb are still high.
// -----------------------------------------------------------------------------
interface mpw_wb_gpio_regbank_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/mpw_wb_gpio_regbank.sv
// -----------------------------------------------------------------------------
// mpw_wb_gpio_regbank
// Wishbone slave GPIO register bank for the user project macro. Gives the
// management SoC output, output-enable, synchronized input and sticky
// edge-interrupt control over NIO user pins.
//
// Ports:
//   wb_clk_i   single clock
//   wb_rst_i   asynchronous active-high reset
//   wbs        Wishbone slave (mpw_wb_gpio_regbank_if.slave)
//   io_in      pad inputs (asynchronous to wb_clk_i)
//   io_out     pad output values
//   io_oeb     pad output enables, active-low
//   irq        user interrupts; irq[0] = |(IRQ_STAT & IRQ_EN), [2:1] tied 0
//   fsm_state  bus FSM state for observation (0 = IDLE, 1 = ACK)
//
// Register map (word offsets from BASE_ADDR, bits >= NIO read 0):
//   0x00 OUT rw, 0x04 OEB rw (reset all 1s), 0x08 IN ro, 0x0C IRQ_EN rw,
//   0x10 IRQ_STAT rw1c, 0x14 ID ro, 0x18 IRQ_EDGE rw (optional).
//   Other offsets inside the 256-byte window ack with read data 0.
//
// Optional feature macro: GPIO_REGBANK_FALLEDGE_EN adds IRQ_EDGE, where bit i
// selects falling-edge (1) instead of rising-edge (0) detection on pin i.
// Without it only rising edges are detected and 0x18 is unmapped.
// -----------------------------------------------------------------------------
module mpw_wb_gpio_regbank #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          NIO       = 17,
  parameter logic [31:0] ID_VALUE  = 32'h4D50_0417
) (
  input  logic                         wb_clk_i,
  input  logic                         wb_rst_i,
  mpw_wb_gpio_regbank_if.slave         wbs,
  input  logic [NIO-1:0]               io_in,
  output logic [NIO-1:0]               io_out,
  output logic [NIO-1:0]               io_oeb,
  output logic [2:0]                   irq,
  output logic                         fsm_state
);

  localparam logic [5:0] OFF_OUT  = 6'd0;
  localparam logic [5:0] OFF_OEB  = 6'd1;
  localparam logic [5:0] OFF_IN   = 6'd2;
  localparam logic [5:0] OFF_EN   = 6'd3;
  localparam logic [5:0] OFF_STAT = 6'd4;
  localparam logic [5:0] OFF_ID   = 6'd5;
`ifdef GPIO_REGBANK_FALLEDGE_EN
  localparam logic [5:0] OFF_EDGE = 6'd6;
`endif

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [5:0]     adr_q;
  logic           req;
  logic           hit;
  logic           ack;
  logic           wr_commit;
  logic [NIO-1:0] wmask;
  logic [NIO-1:0] wdata;
  logic [NIO-1:0] stat_clr;
  logic [NIO-1:0] edge_v;
  logic [31:0]    rdata;

  logic [NIO-1:0] out_q, oeb_q, en_q, stat_q;
  logic [NIO-1:0] sync1_q, sync2_q, prev_q;
`ifdef GPIO_REGBANK_FALLEDGE_EN
  logic [NIO-1:0] edge_sel_q;
`endif

  // Address bits [1:0], write data and byte enables above NIO are don't-care.
  logic unused_ok;
  assign unused_ok = &{1'b0, wbs.wbs_adr_i[1:0], wbs.wbs_dat_i, wbs.wbs_sel_i};

  assign req = wbs.wbs_cyc_i & wbs.wbs_stb_i;
  assign hit = (wbs.wbs_adr_i[31:8] == BASE_ADDR[31:8]);

  // ---------------------------------------------------------------------------
  // Bus FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      adr_q   <= '0;
    end else begin
      state_q <= state_d;
      // The word offset is captured at request time so a read in ACK still
      // returns the right register even if the master drops cyc early.
      if (state_q == ST_IDLE && req && hit) adr_q <= wbs.wbs_adr_i[7:2];
    end
  end

  always_comb begin
    state_d = state_q;
    ack     = 1'b0;
    case (state_q)
      ST_IDLE: if (req && hit) state_d = ST_ACK;
      ST_ACK: begin
        ack     = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign fsm_state     = state_q;
  assign wbs.wbs_ack_o = ack;

  // Writes only take effect if the request is still present in the ack cycle.
  assign wr_commit = ack & req & wbs.wbs_we_i;
  assign wdata     = wbs.wbs_dat_i[NIO-1:0];

  always_comb begin
    wmask = '0;
    for (int i = 0; i < NIO; i++) wmask[i] = wbs.wbs_sel_i[i/8];
  end

  assign stat_clr = (wr_commit && adr_q == OFF_STAT) ? (wdata & wmask) : '0;

  // ---------------------------------------------------------------------------
  // Input synchronizer and edge detect
  // ---------------------------------------------------------------------------
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= io_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

`ifdef GPIO_REGBANK_FALLEDGE_EN
  assign edge_v = (sync2_q & ~prev_q & ~edge_sel_q) | (~sync2_q & prev_q & edge_sel_q);
`else
  assign edge_v = sync2_q & ~prev_q;
`endif

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      out_q  <= '0;
      oeb_q  <= '1;
      en_q   <= '0;
      stat_q <= '0;
    end else begin
      if (wr_commit && adr_q == OFF_OUT) out_q <= (out_q & ~wmask) | (wdata & wmask);
      if (wr_commit && adr_q == OFF_OEB) oeb_q <= (oeb_q & ~wmask) | (wdata & wmask);
      if (wr_commit && adr_q == OFF_EN)  en_q  <= (en_q  & ~wmask) | (wdata & wmask);
      // A new edge overrides a clear landing on the same edge.
      stat_q <= (stat_q & ~stat_clr) | edge_v;
    end
  end

`ifdef GPIO_REGBANK_FALLEDGE_EN
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      edge_sel_q <= '0;
    end else if (wr_commit && adr_q == OFF_EDGE) begin
      edge_sel_q <= (edge_sel_q & ~wmask) | (wdata & wmask);
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Read mux; data bus is zero whenever ack is low.
  // ---------------------------------------------------------------------------
  always_comb begin
    rdata = '0;
    case (adr_q)
      OFF_OUT:  rdata[NIO-1:0] = out_q;
      OFF_OEB:  rdata[NIO-1:0] = oeb_q;
      OFF_IN:   rdata[NIO-1:0] = sync2_q;
      OFF_EN:   rdata[NIO-1:0] = en_q;
      OFF_STAT: rdata[NIO-1:0] = stat_q;
      OFF_ID:   rdata          = ID_VALUE;
`ifdef GPIO_REGBANK_FALLEDGE_EN
      OFF_EDGE: rdata[NIO-1:0] = edge_sel_q;
`endif
      default:  rdata = '0;
    endcase
  end

  assign wbs.wbs_dat_o = ack ? rdata : 32'h0;

  assign io_out = out_q;
  assign io_oeb = oeb_q;
  assign irq    = {2'b00, |(stat_q & en_q)};

endmodule

// File: tb/tb_mpw_wb_gpio_regbank.sv
// -----------------------------------------------------------------------------
// tb_mpw_wb_gpio_regbank
// Self-checking bench for mpw_wb_gpio_regbank: a table of bus vectors with
// hand-computed results, plus hand-written multi-cycle sequences for latency,
// interrupts, set-vs-clear collision, early cyc drop and mid-transfer reset.
// -----------------------------------------------------------------------------
module tb_mpw_wb_gpio_regbank;
  localparam int          NIO  = 17;
  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam logic [31:0] ID   = 32'h4D50_0417;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mpw_wb_gpio_regbank_if bus();
  logic [NIO-1:0] io_in;
  logic [NIO-1:0] io_out;
  logic [NIO-1:0] io_oeb;
  logic [2:0]     irq;
  logic           fsm_state;

  mpw_wb_gpio_regbank #(
    .BASE_ADDR (BASE),
    .NIO       (NIO),
    .ID_VALUE  (ID)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .wbs       (bus),
    .io_in     (io_in),
    .io_out    (io_out),
    .io_oeb    (io_oeb),
    .irq       (irq),
    .fsm_state (fsm_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks (all called at posedge + 1)
  // ---------------------------------------------------------------------------
  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_idle();
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_sel_i = 4'h0;
    bus.wbs_adr_i = 32'h0;
    bus.wbs_dat_i = 32'h0;
  endtask

  task automatic bus_req(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                         input logic [3:0] sel);
    bus.wbs_adr_i = adr;
    bus.wbs_we_i  = we;
    bus.wbs_dat_i = dat;
    bus.wbs_sel_i = sel;
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
  endtask

  // Classic cycle: request held until the end of the ack cycle.
  task automatic wb_xfer(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                         input logic [3:0] sel, output logic [31:0] rdata,
                         output logic acked, output logic ack_one);
    acked   = 1'b0;
    ack_one = 1'b0;
    rdata   = 32'h0;
    bus_req(adr, we, dat, sel);
    for (int n = 0; n < 8; n++) begin
      @(posedge clk);
      #1;
      if (bus.wbs_ack_o) begin
        acked = 1'b1;
        rdata = bus.wbs_dat_o;
        break;
      end
    end
    if (acked) begin
      @(posedge clk);
      #1;
      ack_one = !bus.wbs_ack_o;
    end
    bus_idle();
  endtask

  task automatic wb_read(input string name, input logic [31:0] adr, input logic [31:0] mask,
                         input logic [31:0] exp);
    logic [31:0] rd;
    logic ak, one;
    wb_xfer(adr, 1'b0, 32'h0, 4'hF, rd, ak, one);
    check({name, "_ack"}, {31'h0, ak}, 32'h1);
    check({name, "_data"}, rd & mask, exp);
  endtask

  task automatic wb_write(input string name, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel);
    logic [31:0] rd;
    logic ak, one;
    wb_xfer(adr, 1'b1, dat, sel, rd, ak, one);
    check({name, "_ack"}, {31'h0, ak}, 32'h1);
  endtask

  // ---------------------------------------------------------------------------
  // Vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        exp_ack;
    logic [31:0] exp_dat;
  } vec_t;

  localparam int NV = 25;
  vec_t vec[NV];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic ak, one;

    // OUT holds 0xA5 when the table starts; io_in is 0 throughout.
    vec[0]  = '{1'b0, BASE + 32'h04, 32'h0,         4'hF, 1'b1, 32'h0001_FFFF};
    vec[1]  = '{1'b0, BASE + 32'h14, 32'h0,         4'hF, 1'b1, ID};
    vec[2]  = '{1'b0, BASE + 32'h00, 32'h0,         4'hF, 1'b1, 32'h0000_00A5};
    vec[3]  = '{1'b1, BASE + 32'h00, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'h0};
    vec[4]  = '{1'b0, BASE + 32'h00, 32'h0,         4'hF, 1'b1, 32'h0001_FFFF};
    vec[5]  = '{1'b1, BASE + 32'h00, 32'h1234_5678, 4'h4, 1'b1, 32'h0};
    vec[6]  = '{1'b0, BASE + 32'h00, 32'h0,         4'hF, 1'b1, 32'h0000_FFFF};
    vec[7]  = '{1'b1, BASE + 32'h04, 32'h0,         4'h3, 1'b1, 32'h0};
    vec[8]  = '{1'b0, BASE + 32'h04, 32'h0,         4'hF, 1'b1, 32'h0001_0000};
    vec[9]  = '{1'b1, BASE + 32'h0C, 32'h0000_0008, 4'hF, 1'b1, 32'h0};
    vec[10] = '{1'b0, BASE + 32'h0C, 32'h0,         4'hF, 1'b1, 32'h0000_0008};
    vec[11] = '{1'b0, BASE + 32'h10, 32'h0,         4'hF, 1'b1, 32'h0};
    vec[12] = '{1'b0, BASE + 32'h08, 32'h0,         4'hF, 1'b1, 32'h0};
    vec[13] = '{1'b0, BASE + 32'h20, 32'h0,         4'hF, 1'b1, 32'h0};
    vec[14] = '{1'b1, BASE + 32'h20, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'h0};
    vec[15] = '{1'b0, BASE + 32'h18, 32'h0,         4'hF, 1'b1, 32'h0};
    vec[16] = '{1'b0, BASE + 32'h100, 32'h0,        4'hF, 1'b0, 32'h0};
    vec[17] = '{1'b1, BASE + 32'h100, 32'h0,        4'hF, 1'b0, 32'h0};
    vec[18] = '{1'b1, 32'h2FFF_FF00, 32'h0,         4'hF, 1'b0, 32'h0};
    vec[19] = '{1'b0, BASE + 32'h00, 32'h0,         4'hF, 1'b1, 32'h0000_FFFF};
    vec[20] = '{1'b1, BASE + 32'h14, 32'h0,         4'hF, 1'b1, 32'h0};
    vec[21] = '{1'b0, BASE + 32'h14, 32'h0,         4'hF, 1'b1, ID};
    vec[22] = '{1'b1, BASE + 32'h0C, 32'h0,         4'hE, 1'b1, 32'h0};
    vec[23] = '{1'b0, BASE + 32'h0C, 32'h0,         4'hF, 1'b1, 32'h0000_0008};
    vec[24] = '{1'b0, BASE + 32'h3C, 32'h0,         4'hF, 1'b1, 32'h0};

    // ---- reset ----
    bus_idle();
    io_in = '0;
    rst   = 1'b1;
    cycles(3);
    check("rst_ack",    {31'h0, bus.wbs_ack_o}, 32'h0);
    check("rst_dat",    bus.wbs_dat_o, 32'h0);
    rst = 1'b0;
    cycles(1);
    check("rst_io_out", {15'h0, io_out}, 32'h0);
    check("rst_io_oeb", {15'h0, io_oeb}, 32'h0001_FFFF);
    check("rst_irq",    {29'h0, irq}, 32'h0);

    // ---- byte-enabled write: latency and ack width ----
    bus_req(BASE, 1'b1, 32'h0000_A5A5, 4'b0001);
    cycles(1);
    check("lat_ack_hi",   {31'h0, bus.wbs_ack_o}, 32'h1);
    check("lat_out_old",  {15'h0, io_out}, 32'h0);
    cycles(1);
    check("lat_ack_lo",   {31'h0, bus.wbs_ack_o}, 32'h0);
    check("lat_out_new",  {15'h0, io_out}, 32'h0000_00A5);
    bus_idle();

    // ---- table ----
    for (int i = 0; i < NV; i++) begin
      wb_xfer(vec[i].adr, vec[i].we, vec[i].dat, vec[i].sel, rd, ak, one);
      check($sformatf("v%0d_ack", i), {31'h0, ak}, {31'h0, vec[i].exp_ack});
      if (ak) check($sformatf("v%0d_ack_width", i), {31'h0, one}, 32'h1);
      if (!vec[i].we && vec[i].exp_ack) begin
        exp_q.push_back(vec[i].exp_dat);
        check($sformatf("v%0d_rdata", i), rd, exp_q.pop_front());
      end
    end
    check("tbl_io_out", {15'h0, io_out}, 32'h0000_FFFF);
    check("tbl_io_oeb", {15'h0, io_oeb}, 32'h0001_0000);

    // ---- edge interrupt on pin 3 (IRQ_EN = 0x8 from the table) ----
    io_in[3] = 1'b1;
    cycles(1);
    check("edge_irq_k",  {29'h0, irq}, 32'h0);
    cycles(1);
    check("edge_irq_k1", {29'h0, irq}, 32'h0);
    cycles(1);
    check("edge_irq_k2", {29'h0, irq}, 32'h1);
    wb_read("edge_stat", BASE + 32'h10, 32'hFFFF_FFFF, 32'h8);
    wb_read("edge_in",   BASE + 32'h08, 32'hFFFF_FFFF, 32'h8);
    wb_write("w1c_badsel", BASE + 32'h10, 32'h8, 4'b1110);
    wb_read("w1c_badsel_stat", BASE + 32'h10, 32'hFFFF_FFFF, 32'h8);
    wb_write("w1c_zero", BASE + 32'h10, 32'h0, 4'hF);
    wb_read("w1c_zero_stat", BASE + 32'h10, 32'hFFFF_FFFF, 32'h8);
    wb_write("w1c", BASE + 32'h10, 32'h8, 4'hF);
    check("w1c_irq", {29'h0, irq}, 32'h0);
    wb_read("w1c_stat", BASE + 32'h10, 32'hFFFF_FFFF, 32'h0);

    // ---- set wins over same-edge clear ----
    io_in[3] = 1'b0;
    cycles(3);
    io_in[3] = 1'b1;
    cycles(3);
    wb_read("col_pre", BASE + 32'h10, 32'hFFFF_FFFF, 32'h8);
    io_in[3] = 1'b0;
    cycles(3);
    io_in[3] = 1'b1;                       // edge K is the next posedge
    cycles(1);
    bus_req(BASE + 32'h10, 1'b1, 32'h8, 4'hF);
    cycles(1);                             // edge K+1: request sampled
    check("col_ack", {31'h0, bus.wbs_ack_o}, 32'h1);
    cycles(1);                             // edge K+2: set and clear together
    bus_idle();
    wb_read("col_stat", BASE + 32'h10, 32'hFFFF_FFFF, 32'h8);
    wb_write("col_clr", BASE + 32'h10, 32'h8, 4'hF);
    wb_read("col_clr_stat", BASE + 32'h10, 32'hFFFF_FFFF, 32'h0);

    // ---- cyc dropped during ack: ack completes, write is dropped ----
    bus_req(BASE, 1'b1, 32'h0, 4'hF);
    cycles(1);
    check("drop_ack_hi", {31'h0, bus.wbs_ack_o}, 32'h1);
    bus_idle();
    cycles(1);
    check("drop_ack_lo", {31'h0, bus.wbs_ack_o}, 32'h0);
    wb_read("drop_out", BASE, 32'hFFFF_FFFF, 32'h0000_FFFF);

    // ---- reset in the middle of a write; pin 3 is high across reset ----
    bus_req(BASE, 1'b1, 32'h0000_0001, 4'hF);
    cycles(1);
    check("mrst_ack_hi", {31'h0, bus.wbs_ack_o}, 32'h1);
    rst = 1'b1;
    #1;
    check("mrst_ack_lo", {31'h0, bus.wbs_ack_o}, 32'h0);
    check("mrst_dat",    bus.wbs_dat_o, 32'h0);
    cycles(1);
    bus_idle();
    cycles(1);
    rst = 1'b0;
    check("mrst_io_out", {15'h0, io_out}, 32'h0);
    check("mrst_io_oeb", {15'h0, io_oeb}, 32'h0001_FFFF);
    check("mrst_irq",    {29'h0, irq}, 32'h0);
    cycles(3);
    wb_read("mrst_stat", BASE + 32'h10, 32'hFFFF_FFFF, 32'h8);
    wb_read("mrst_en",   BASE + 32'h0C, 32'hFFFF_FFFF, 32'h0);
    wb_read("mrst_out",  BASE + 32'h00, 32'hFFFF_FFFF, 32'h0);

    // ---- input register pattern ----
    io_in = 17'h1A5A5;
    cycles(3);
    wb_read("in_pat", BASE + 32'h08, 32'hFFFF_FFFF, 32'h0001_A5A5);
    wb_write("in_clr", BASE + 32'h10, 32'hFFFF_FFFF, 4'hF);
    wb_read("in_clr_stat", BASE + 32'h10, 32'hFFFF_FFFF, 32'h0);

`ifdef GPIO_REGBANK_FALLEDGE_EN
    // ---- falling-edge select on pin 0 ----
    wb_write("fe_cfg", BASE + 32'h18, 32'h1, 4'hF);
    wb_read("fe_cfg_rd", BASE + 32'h18, 32'hFFFF_FFFF, 32'h1);
    io_in[0] = 1'b0;
    cycles(3);
    wb_read("fe_fall", BASE + 32'h10, 32'h1, 32'h1);
    wb_write("fe_clr", BASE + 32'h10, 32'h1, 4'hF);
    io_in[0] = 1'b1;
    cycles(3);
    wb_read("fe_rise", BASE + 32'h10, 32'h1, 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
